finite_state_machine: RTL and testbench

FINITE_STATE_MACHINE -- requirements
Module: finite_state_machine

---
 rtl/finite_state_machine.sv | 22 ++
 tb/tb_finite_state_machine.sv | 103 ++++++++++
 2 files changed

// File: rtl/finite_state_machine.sv
// finite_state_machine: Mealy detector for serial pattern 1-0-1 with overlap.
// out is combinational from state and in; illegal encoding 2'b11 recovers to S0.
`timescale 1ns/1ps
module finite_state_machine (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S10 = 2'b10} state_t;
    state_t state_q, state_d;
    logic   legal;
    always_comb begin
        legal   = (state_q == S0) || (state_q == S1) || (state_q == S10);
        state_d = !legal ? S0 : in ? S1 : (state_q == S1) ? S10 : S0;
        out     = (state_q == S10) && in;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S0;
        else        state_q <= state_d;
    end
endmodule

// File: tb/tb_finite_state_machine.sv
// tb_finite_state_machine: table-driven check of the 1-0-1 detector plus
// hand-written reset and long-run sequences.
`timescale 1ns/1ps
module tb_finite_state_machine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0;
    logic dout;
    int   checks = 0;
    int   failures = 0;
    finite_state_machine dut (.clk(clk), .reset(reset), .in(din), .out(dout));
    always #5 clk = ~clk;
    typedef struct {
        bit       rst;
        bit       in_b;
        bit       exp;
        bit       chk;
        bit [1:0] st;
    } vec_t;
    vec_t vecs[17];
    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask
    // One bit per cycle: optional state check after the edge, drive at +5, optional
    // 1 ns reset pulse, then sample out just before the next edge.
    task automatic step(input bit r, input bit b, input bit e, input bit c,
                        input bit [1:0] s, input string nm);
        @(posedge clk);
        #1;
        if (c) chk({nm, "_state"}, dut.state_q, s);
        #4;
        din = b;
        if (r) begin
            reset = 1'b0;
            #1;
            reset = 1'b1;
        end
        #2;
        chk({nm, "_out"}, {1'b0, dout}, {1'b0, e});
    endtask
    initial begin
        vecs[0]  = '{1, 1, 0, 0, 2'b00};
        vecs[1]  = '{0, 0, 0, 1, 2'b01};
        vecs[2]  = '{0, 1, 1, 1, 2'b10};
        vecs[3]  = '{1, 1, 0, 1, 2'b01};
        vecs[4]  = '{0, 0, 0, 0, 2'b00};
        vecs[5]  = '{0, 1, 1, 0, 2'b00};
        vecs[6]  = '{0, 0, 0, 1, 2'b01};
        vecs[7]  = '{0, 1, 1, 1, 2'b10};
        vecs[8]  = '{1, 1, 0, 1, 2'b01};
        vecs[9]  = '{0, 1, 0, 1, 2'b01};
        vecs[10] = '{0, 0, 0, 1, 2'b01};
        vecs[11] = '{0, 0, 0, 1, 2'b10};
        vecs[12] = '{0, 1, 0, 1, 2'b00};
        vecs[13] = '{1, 1, 0, 1, 2'b01};
        vecs[14] = '{0, 1, 0, 0, 2'b00};
        vecs[15] = '{0, 0, 0, 0, 2'b00};
        vecs[16] = '{0, 1, 1, 1, 2'b10};
        // Short reset pulse with no clock edge in it.
        #1;
        din = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_pulse_state", dut.state_q, 2'b00);
        chk("rst_pulse_out", {1'b0, dout}, 2'b00);
        reset = 1'b1;
        for (int i = 0; i < 17; i++)
            step(vecs[i].rst, vecs[i].in_b, vecs[i].exp, vecs[i].chk, vecs[i].st,
                 $sformatf("vec%0d", i));
        // Mid-match reset: 1,0 then reset while in=1 in the S10 cycle.
        step(1, 1, 0, 0, 2'b00, "mm_b1");
        step(0, 0, 0, 0, 2'b00, "mm_b0");
        @(posedge clk);
        #5;
        din = 1'b1;
        #1;
        chk("mm_pre_out", {1'b0, dout}, 2'b01);
        reset = 1'b0;
        #1;
        chk("mm_rst_out", {1'b0, dout}, 2'b00);
        chk("mm_rst_state", dut.state_q, 2'b00);
        reset = 1'b1;
        #1;
        chk("mm_rel_out", {1'b0, dout}, 2'b00);
        @(posedge clk);
        #1;
        chk("mm_after_state", dut.state_q, 2'b01);
        // Long run of ones: never detects, parks in S1.
        step(1, 1, 0, 0, 2'b00, "long0");
        for (int i = 1; i < 10; i++)
            step(0, 1, 0, 1, 2'b01, $sformatf("long%0d", i));
        @(posedge clk);
        #1;
        chk("long_end_state", dut.state_q, 2'b01);
        chk("long_end_out", {1'b0, dout}, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
